// File: rtl/exe_stage.sv
// Execute stage: Val2 operand generator, ALU with NZCV flags, branch-target adder,
// status register and the EX/MEM pipeline register.
module exe_stage #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         freeze,
    input  logic [3:0]   EXE_CMD,
    input  logic         S,
    input  logic         B,
    input  logic         imm,
    input  logic         MEM_R_EN,
    input  logic         MEM_W_EN,
    input  logic         WB_EN,
    input  logic [3:0]   Dest,
    input  logic [n-1:0] Val_Rn,
    input  logic [n-1:0] Val_Rm,
    input  logic [n-1:0] PC,
    input  logic [23:0]  Signed_imm_24,
    input  logic [11:0]  Shift_operand,
    output logic         Branch_taken,
    output logic [n-1:0] Branch_Address,
    output logic [3:0]   SR,
    output logic [n-1:0] ALU_Res_out,
    output logic [n-1:0] Val_Rm_out,
    output logic [3:0]   Dest_out,
    output logic         WB_EN_out,
    output logic         MEM_R_EN_out,
    output logic         MEM_W_EN_out
);

    logic [31:0] imm8_s;
    logic [5:0]  imm_rot_s;
    logic [31:0] imm_val_s;
    logic [4:0]  shamt_s;
    logic [31:0] ror_s;
    logic [31:0] val2_s;
    logic [32:0] sum_s;
    logic [31:0] res_s;
    logic        c_s;
    logic        v_s;
    logic [3:0]  flags_s;

    // Rotate-by-zero must be a no-op; a shift by the full width yields zero, so the OR stays exact.
    assign imm8_s    = {24'd0, Shift_operand[7:0]};
    assign imm_rot_s = {1'b0, Shift_operand[11:8], 1'b0};
    assign imm_val_s = (imm8_s >> imm_rot_s) | (imm8_s << (6'd32 - imm_rot_s));
    assign shamt_s   = Shift_operand[11:7];
    assign ror_s     = (Val_Rm >> shamt_s) | (Val_Rm << (6'd32 - {1'b0, shamt_s}));

    assign Branch_taken   = B;
    assign Branch_Address = PC + {{6{Signed_imm_24[23]}}, Signed_imm_24, 2'b00};

    // Second-operand selection: immediate, memory offset, or shifted register.
    always_comb begin
        val2_s = Val_Rm;
        if (imm) begin
            val2_s = imm_val_s;
        end else if (MEM_R_EN || MEM_W_EN) begin
            val2_s = {20'd0, Shift_operand};
        end else if (shamt_s == 5'd0) begin
            val2_s = Val_Rm;
        end else begin
            case (Shift_operand[6:5])
                2'b00:   val2_s = Val_Rm << shamt_s;
                2'b01:   val2_s = Val_Rm >> shamt_s;
                2'b10:   val2_s = $unsigned($signed(Val_Rm) >>> shamt_s);
                2'b11:   val2_s = ror_s;
                default: val2_s = Val_Rm;
            endcase
        end
    end

    // ALU; subtraction is Rn + ~Val2 + 1 so bit 32 is directly the ARM "not borrow" carry.
    always_comb begin
        sum_s = 33'd0;
        res_s = 32'd0;
        c_s   = SR[1];
        v_s   = SR[0];
        case (EXE_CMD)
            4'b0001: res_s = val2_s;
            4'b1001: res_s = ~val2_s;
            4'b0010, 4'b0011: begin
                sum_s = {1'b0, Val_Rn} + {1'b0, val2_s}
                        + {32'd0, (EXE_CMD == 4'b0011) ? SR[1] : 1'b0};
                res_s = sum_s[31:0];
                c_s   = sum_s[32];
                v_s   = (Val_Rn[31] == val2_s[31]) && (sum_s[31] != Val_Rn[31]);
            end
            4'b0100, 4'b0101: begin
                sum_s = {1'b0, Val_Rn} + {1'b0, ~val2_s}
                        + {32'd0, (EXE_CMD == 4'b0101) ? SR[1] : 1'b1};
                res_s = sum_s[31:0];
                c_s   = sum_s[32];
                v_s   = (Val_Rn[31] != val2_s[31]) && (sum_s[31] != Val_Rn[31]);
            end
            4'b0110: res_s = Val_Rn & val2_s;
            4'b0111: res_s = Val_Rn | val2_s;
            4'b1000: res_s = Val_Rn ^ val2_s;
            default: res_s = 32'd0;
        endcase
        flags_s = {res_s[31], (res_s == 32'd0), c_s, v_s};
    end

    // Status register: updates only for flag-setting instructions outside a stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            SR <= 4'd0;
        end else if (S && !freeze) begin
            SR <= flags_s;
        end
    end

    // EX/MEM pipeline register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ALU_Res_out  <= 32'd0;
            Val_Rm_out   <= 32'd0;
            Dest_out     <= 4'd0;
            WB_EN_out    <= 1'b0;
            MEM_R_EN_out <= 1'b0;
            MEM_W_EN_out <= 1'b0;
        end else if (!freeze) begin
            ALU_Res_out  <= res_s;
            Val_Rm_out   <= Val_Rm;
            Dest_out     <= Dest;
            WB_EN_out    <= WB_EN;
            MEM_R_EN_out <= MEM_R_EN;
            MEM_W_EN_out <= MEM_W_EN;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: directed vectors push expected EX/MEM state,
// a monitor pops and compares one cycle later.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst, freeze, S, B, imm, MEM_R_EN, MEM_W_EN, WB_EN;
    logic [3:0]  EXE_CMD, Dest;
    logic [31:0] Val_Rn, Val_Rm, PC;
    logic [23:0] Signed_imm_24;
    logic [11:0] Shift_operand;
    logic        Branch_taken, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out;
    logic [31:0] Branch_Address, ALU_Res_out, Val_Rm_out;
    logic [3:0]  SR, Dest_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic [31:0] rm;
        logic [3:0]  dest;
        logic [3:0]  sr;
        logic        wb, mr, mw;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t last_exp;

    exe_stage dut (
        .clk(clk), .rst(rst), .freeze(freeze), .EXE_CMD(EXE_CMD), .S(S), .B(B), .imm(imm),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .WB_EN(WB_EN), .Dest(Dest),
        .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .PC(PC), .Signed_imm_24(Signed_imm_24),
        .Shift_operand(Shift_operand), .Branch_taken(Branch_taken),
        .Branch_Address(Branch_Address), .SR(SR), .ALU_Res_out(ALU_Res_out),
        .Val_Rm_out(Val_Rm_out), .Dest_out(Dest_out), .WB_EN_out(WB_EN_out),
        .MEM_R_EN_out(MEM_R_EN_out), .MEM_W_EN_out(MEM_W_EN_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic issue(input string nm, input logic [3:0] cmd, input logic s, input logic im,
                         input logic mr, input logic mw, input logic wb, input logic [3:0] dst,
                         input logic [31:0] rn, input logic [31:0] rm, input logic [11:0] so,
                         input logic frz, input logic [31:0] exp_res, input logic [3:0] exp_sr);
        exp_t e;
        @(negedge clk);
        EXE_CMD = cmd; S = s; imm = im; MEM_R_EN = mr; MEM_W_EN = mw; WB_EN = wb;
        Dest = dst; Val_Rn = rn; Val_Rm = rm; Shift_operand = so; freeze = frz;
        B = 1'b0; PC = 32'd0; Signed_imm_24 = 24'd0;
        if (frz) begin
            e = last_exp;
        end else begin
            e.res = exp_res; e.sr = exp_sr; e.rm = rm; e.dest = dst;
            e.wb = wb; e.mr = mr; e.mw = mw;
        end
        e.name = nm;
        last_exp = e;
        q.push_back(e);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_res"}, {32'd0, ALU_Res_out}, 64'd0);
        chk({nm, "_rm"}, {32'd0, Val_Rm_out}, 64'd0);
        chk({nm, "_sr"}, {60'd0, SR}, 64'd0);
        chk({nm, "_ctl"}, {57'd0, Dest_out, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out}, 64'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("drain_timeout", {63'd0, q.size() == 0}, 64'd1);
    endtask

    // Monitor: compares registered outputs just after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({e.name, "_res"}, {32'd0, ALU_Res_out}, {32'd0, e.res});
            chk({e.name, "_sr"}, {60'd0, SR}, {60'd0, e.sr});
            chk({e.name, "_pass"}, {25'd0, Val_Rm_out, Dest_out, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out},
                {25'd0, e.rm, e.dest, e.wb, e.mr, e.mw});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        last_exp = '{res: 32'd0, rm: 32'd0, dest: 4'd0, sr: 4'd0, wb: 1'b0, mr: 1'b0, mw: 1'b0, name: "init"};
        // Garbage inputs under reset
        rst = 1'b0; freeze = 1'b0; EXE_CMD = 4'b0010; S = 1'b1; B = 1'b0; imm = 1'b1;
        MEM_R_EN = 1'b1; MEM_W_EN = 1'b1; WB_EN = 1'b1; Dest = 4'hA;
        Val_Rn = 32'hDEADBEEF; Val_Rm = 32'hCAFEF00D; PC = 32'h1234; Signed_imm_24 = 24'h55AA55;
        Shift_operand = 12'hABC;
        @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        q.push_back('{res: 32'd12, rm: 32'd7, dest: 4'd3, sr: 4'b0000, wb: 1'b1, mr: 1'b0, mw: 1'b0, name: "add_5_7"});
        EXE_CMD = 4'b0010; S = 1'b1; imm = 1'b0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; WB_EN = 1'b1;
        Dest = 4'd3; Val_Rn = 32'd5; Val_Rm = 32'd7; Shift_operand = 12'h000;
        last_exp = q[0];

        issue("add_ovf", 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 32'h7FFFFFFF, 32'd1, 12'h000, 1'b0, 32'h80000000, 4'b1001);
        issue("undef_cmd", 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 32'h12345678, 32'h55, 12'h000, 1'b0, 32'd0, 4'b0101);
        issue("cmp_5_5", 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd5, 32'd5, 12'h000, 1'b0, 32'd0, 4'b0110);
        issue("adc_carry", 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 32'hFFFFFFFF, 32'd0, 12'h000, 1'b0, 32'd0, 4'b0110);
        issue("sbc_10_3", 4'b0101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 32'd10, 32'd3, 12'h000, 1'b0, 32'd7, 4'b0010);
        issue("mov_imm_rot", 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd6, 32'd0, 32'h11, 12'h4FF, 1'b0, 32'hFF000000, 4'b0010);
        issue("mov_asr4", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd6, 32'd0, 32'h80000000, 12'h240, 1'b0, 32'hF8000000, 4'b1010);
        issue("mvn_zero", 4'b1001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd8, 32'd0, 32'd0, 12'h000, 1'b0, 32'hFFFFFFFF, 4'b1010);
        issue("ldr_offs", 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 32'h400, 32'hDEADBEEF, 12'h010, 1'b0, 32'h410, 4'b1010);
        issue("eor_lsl4", 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 32'hF0F0F0F0, 32'h0F, 12'h200, 1'b0, 32'hF0F0F000, 4'b1010);
        issue("orr_ror8", 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 32'h1, 32'hFF, 12'h460, 1'b0, 32'hFF000001, 4'b1010);
        issue("branch_nop", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 12'h000, 1'b0, 32'd0, 4'b1010);
        B = 1'b1; PC = 32'h100; Signed_imm_24 = 24'hFFFFFE;
        #1;
        chk("branch_taken", {63'd0, Branch_taken}, 64'd1);
        chk("branch_addr_back", {32'd0, Branch_Address}, 64'hF8);
        PC = 32'hFFFFFFF0; Signed_imm_24 = 24'h000008;
        #1;
        chk("branch_addr_wrap", {32'd0, Branch_Address}, 64'h10);

        issue("add_1_1", 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 32'd1, 32'd1, 12'h000, 1'b0, 32'd2, 4'b0000);
        for (int i = 0; i < 3; i++)
            issue("frozen_sub", 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 32'd1, 32'd2, 12'h000, 1'b1, 32'd0, 4'd0);
        issue("unfrozen_sub", 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 32'd1, 32'd2, 12'h000, 1'b0, 32'hFFFFFFFF, 4'b1000);
        issue("frozen_add", 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 32'd3, 32'd4, 12'h001, 1'b1, 32'd0, 4'd0);
        drain();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk_zero("rst_mid_freeze");

        last_exp = '{res: 32'd0, rm: 32'd0, dest: 4'd0, sr: 4'd0, wb: 1'b0, mr: 1'b0, mw: 1'b0, name: "rst"};
        @(negedge clk);
        rst = 1'b1;
        issue("post_rst_add", 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 32'd3, 32'd4, 12'h000, 1'b0, 32'd7, 4'b0000);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
